// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the instruction encoder: class codes, opcode
// prefixes, register codes and the NOP word used for tail padding.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    CLS_LOAD  = 3'd0,
    CLS_MOVE  = 3'd1,
    CLS_ALU   = 3'd2,
    CLS_JUMP  = 3'd3,
    CLS_CJUMP = 3'd4
  } instr_class_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_PAD,
    ST_DONE
  } enc_state_t;

  localparam logic [0:0] PFX_LOAD  = 1'b0;
  localparam logic [1:0] PFX_MOVE  = 2'b10;
  localparam logic [2:0] PFX_ALU   = 3'b110;
  localparam logic [3:0] PFX_JUMP  = 4'b1110;
  localparam logic [3:0] PFX_CJUMP = 4'b1111;

  localparam logic [2:0] REG_X0 = 3'd0;
  localparam logic [2:0] REG_X1 = 3'd1;
  localparam logic [2:0] REG_Y0 = 3'd2;
  localparam logic [2:0] REG_Y1 = 3'd3;
  localparam logic [2:0] REG_RO = 3'd4;
  localparam logic [2:0] REG_M  = 3'd5;
  localparam logic [2:0] REG_I  = 3'd6;
  localparam logic [2:0] REG_DM = 3'd7;

  // MOVE x0 <- x0 has no architectural effect, so it doubles as the NOP.
  localparam logic [7:0] NOP_WORD = {PFX_MOVE, REG_X0, REG_X0};

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: instruction class plus fields to an 8-bit word, with a
// flag for class codes that have no encoding.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0] i_class,
  input  logic [2:0] i_dst,
  input  logic [2:0] i_src,
  input  logic [3:0] i_data,
  input  logic       i_x_sel,
  input  logic       i_y_sel,
  output logic [7:0] o_word,
  output logic       o_illegal
);

  always_comb begin
    o_word    = NOP_WORD;
    o_illegal = 1'b0;
    case (i_class)
      CLS_LOAD:  o_word = {PFX_LOAD, i_dst, i_data};
      CLS_MOVE:  o_word = {PFX_MOVE, i_dst, i_src};
      CLS_ALU:   o_word = {PFX_ALU, i_x_sel, i_y_sel, i_data[2:0]};
      CLS_JUMP:  o_word = {PFX_JUMP, i_data};
      CLS_CJUMP: o_word = {PFX_CJUMP, i_data};
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Program loader: encodes valid/ready instruction requests and writes them to
// program memory. Define INSTR_ENCODER_NOP_PAD_EN to NOP-fill the tail on finish.
module instruction_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              sync_reset_n,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_class,
  input  logic [2:0]        req_dst,
  input  logic [2:0]        req_src,
  input  logic [3:0]        req_data,
  input  logic              req_x_sel,
  input  logic              req_y_sel,
  output logic              pm_wr_en,
  output logic [ADDR_W-1:0] pm_wr_addr,
  output logic [7:0]        pm_wr_data,
  output logic [ADDR_W:0]   instr_count,
  output logic              illegal,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  enc_state_t        r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic              r_illegal;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;

  logic [7:0]        w_word;
  logic              w_cls_illegal;
  logic              w_accept;
  logic              w_legal_acc;
  logic [ADDR_W:0]   w_count_inc;

  instr_pack u_pack (
    .i_class   (req_class),
    .i_dst     (req_dst),
    .i_src     (req_src),
    .i_data    (req_data),
    .i_x_sel   (req_x_sel),
    .i_y_sel   (req_y_sel),
    .o_word    (w_word),
    .o_illegal (w_cls_illegal)
  );

  assign req_ready   = (r_state == ST_STREAM) && (r_count < FULL_COUNT);
  assign w_accept    = req_valid && req_ready;
  assign w_legal_acc = w_accept && !w_cls_illegal;
  assign w_count_inc = r_count + (ADDR_W + 1)'(1);

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_state_next = ST_STREAM;
      end
      ST_STREAM: begin
        // Filling the last word wins over a coincident finish: nothing left to pad.
        if (w_legal_acc && (w_count_inc == FULL_COUNT)) begin
          w_state_next = ST_DONE;
        end else if (finish) begin
`ifdef INSTR_ENCODER_NOP_PAD_EN
          w_state_next = ST_PAD;
`else
          w_state_next = ST_DONE;
`endif
        end
      end
`ifdef INSTR_ENCODER_NOP_PAD_EN
      ST_PAD: begin
        if (r_addr == {ADDR_W{1'b1}}) w_state_next = ST_DONE;
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      r_addr    <= '0;
      r_count   <= '0;
      r_illegal <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_addr    <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (w_accept && w_cls_illegal) begin
            r_illegal <= 1'b1;
          end else if (w_legal_acc) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= w_word;
            r_addr    <= r_addr + ADDR_W'(1);
            r_count   <= w_count_inc;
          end
        end
`ifdef INSTR_ENCODER_NOP_PAD_EN
        ST_PAD: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_addr;
          r_wr_data <= NOP_WORD;
          r_addr    <= r_addr + ADDR_W'(1);
        end
`endif
        default: ;
      endcase
    end
  end

  assign pm_wr_en    = r_wr_en;
  assign pm_wr_addr  = r_wr_addr;
  assign pm_wr_data  = r_wr_data;
  assign instr_count = r_count;
  assign illegal     = r_illegal;
  assign done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder (ADDR_W=3): directed cases plus
// randomized sessions checked against an arithmetic reference model.
module tb_instruction_encoder;

  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          sync_reset_n;
  logic          start, finish, req_valid, req_ready;
  logic [2:0]    req_class, req_dst, req_src;
  logic [3:0]    req_data;
  logic          req_x_sel, req_y_sel;
  logic          pm_wr_en;
  logic [AW-1:0] pm_wr_addr;
  logic [7:0]    pm_wr_data;
  logic [AW:0]   instr_count;
  logic          illegal, done;

  instruction_encoder #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .start        (start),
    .finish       (finish),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_class    (req_class),
    .req_dst      (req_dst),
    .req_src      (req_src),
    .req_data     (req_data),
    .req_x_sel    (req_x_sel),
    .req_y_sel    (req_y_sel),
    .pm_wr_en     (pm_wr_en),
    .pm_wr_addr   (pm_wr_addr),
    .pm_wr_data   (pm_wr_data),
    .instr_count  (instr_count),
    .illegal      (illegal),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];  // expected writes, packed as addr*256 + data

  // Model session state: 0 idle, 1 streaming, 2 finished (padding folded in)
  int m_state = 0;
  int m_addr = 0, m_count = 0, m_illegal = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int ref_encode(input int cls, input int dst, input int src,
                                    input int data, input int x, input int y);
    case (cls)
      0:       return dst * 16 + data;
      1:       return 128 + dst * 8 + src;
      2:       return 192 + x * 16 + y * 8 + (data % 8);
      3:       return 224 + data;
      4:       return 240 + data;
      default: return -1;
    endcase
  endfunction

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (pm_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write",
                 pm_wr_addr, pm_wr_data);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("wr_addr", int'(pm_wr_addr), e / 256);
        chk("wr_data", int'(pm_wr_data), e % 256);
      end
    end
  end

  task automatic model_finish();
    if (m_state == 1) begin
`ifdef INSTR_ENCODER_NOP_PAD_EN
      for (int a = m_addr; a < DEPTH; a++) exp_q.push_back(a * 256 + 8'h80);
`endif
      m_state = 2;
    end
  endtask

  // Called #1 after a posedge; returns #1 after the edge that sampled the request.
  task automatic issue(input int cls, input int dst, input int src, input int data,
                       input int x, input int y, input bit fin);
    bit acc;
    int enc;
    req_valid = 1'b1;
    req_class = 3'(cls);
    req_dst   = 3'(dst);
    req_src   = 3'(src);
    req_data  = 4'(data);
    req_x_sel = x[0];
    req_y_sel = y[0];
    finish    = fin;
    @(negedge clk);
    chk("req_ready", int'(req_ready), (m_state == 1 && m_count < DEPTH) ? 1 : 0);
    acc = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    finish    = 1'b0;
    if (acc) begin
      enc = ref_encode(cls, dst, src, data, x, y);
      if (enc < 0) begin
        m_illegal = 1;
      end else begin
        exp_q.push_back(m_addr * 256 + enc);
        m_addr++;
        m_count++;
        if (m_count == DEPTH) m_state = 2;
      end
    end
    if (fin) model_finish();
    $display("req cls=%0d dst=%0d src=%0d data=%0d x=%0d y=%0d fin=%0d acc=%0d count=%0d",
             cls, dst, src, data, x, y, fin, acc, m_count);
    chk("instr_count", int'(instr_count), m_count);
    chk("illegal", int'(illegal), m_illegal);
  endtask

  task automatic issue_rand(input bit fin);
    issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1), fin);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_state = 1; m_addr = 0; m_count = 0; m_illegal = 0;
    $display("start session");
    chk("start_count", int'(instr_count), 0);
    chk("start_illegal", int'(illegal), 0);
    chk("start_done", int'(done), 0);
    chk("start_ready", int'(req_ready), 1);
  endtask

  task automatic do_finish();
    finish = 1'b1;
    @(posedge clk);
    #1;
    finish = 1'b0;
    model_finish();
    $display("finish session count=%0d", m_count);
  endtask

  task automatic wait_done();
    for (int i = 0; i < DEPTH + 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    chk("done_wait", int'(done), 1);
    @(negedge clk);
    chk("pending_writes", exp_q.size(), 0);
    chk("done_ready", int'(req_ready), 0);
    chk("done_count", int'(instr_count), m_count);
    chk("done_illegal", int'(illegal), m_illegal);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ready"}, int'(req_ready), 0);
    chk({tag, "_wr_en"}, int'(pm_wr_en), 0);
    chk({tag, "_wr_addr"}, int'(pm_wr_addr), 0);
    chk({tag, "_wr_data"}, int'(pm_wr_data), 0);
    chk({tag, "_count"}, int'(instr_count), 0);
    chk({tag, "_illegal"}, int'(illegal), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    sync_reset_n = 1'b0;
    start = 1'b0; finish = 1'b0; req_valid = 1'b0;
    req_class = '0; req_dst = '0; req_src = '0; req_data = '0;
    req_x_sel = 1'b0; req_y_sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    sync_reset_n = 1'b1;

    // Single LOAD
    do_start();
    issue(0, 0, 0, 5, 0, 0, 1'b0);
    do_finish();
    wait_done();

    // Back-to-back mixed classes, finish coinciding with the last request
    do_start();
    issue(1, 4, 6, 0, 0, 0, 1'b0);
    issue(2, 0, 0, 3, 1, 0, 1'b0);
    issue(3, 0, 0, 9, 0, 0, 1'b0);
    issue(4, 0, 0, 2, 0, 0, 1'b1);
    wait_done();

    // Illegal class between two LOADs
    do_start();
    issue(0, 3, 0, 10, 0, 0, 1'b0);
    issue(6, 1, 1, 1, 1, 1, 1'b0);
    issue(0, 7, 0, 15, 0, 0, 1'b0);
    do_finish();
    wait_done();

    // Fill memory; a further request must never be accepted
    do_start();
    for (int i = 0; i < DEPTH; i++) issue($urandom_range(0, 4), i % 8, 7 - i % 8, i, i % 2, 1, 1'b0);
    chk("full_done", int'(done), 1);
    req_valid = 1'b1;
    req_class = 3'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_blocked_ready", int'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_done();

    // Two writes then finish: tail padding when compiled in
    do_start();
    issue(0, 1, 0, 1, 0, 0, 1'b0);
    issue(0, 2, 0, 2, 0, 0, 1'b0);
    do_finish();
    wait_done();

    // Reset mid-stream abandons the session
    do_start();
    for (int i = 0; i < 3; i++) issue_rand(1'b0);
    sync_reset_n = 1'b0;
    @(posedge clk);
    #1;
    sync_reset_n = 1'b1;
    exp_q.delete();
    m_state = 0; m_addr = 0; m_count = 0; m_illegal = 0;
    $display("mid-session reset");
    check_outputs_zero("midreset");
    repeat (2) begin
      @(negedge clk);
      chk("idle_ready", int'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    do_start();
    issue(3, 0, 0, 12, 0, 0, 1'b0);
    do_finish();
    wait_done();

    // Randomized sessions
    for (int s = 0; s < 25; s++) begin
      int len;
      len = $urandom_range(0, 11);
      do_start();
      for (int k = 0; k < len && m_state == 1; k++)
        issue_rand((k == len - 1) && ($urandom_range(0, 1) == 1));
      if (m_state == 1) do_finish();
      wait_done();
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Encodes a stream of symbolic instruction requests (class plus fields) into the 8-bit instruction words consumed by the processor's instruction decoder.
- Writes the encoded words sequentially into program memory through a registered write port.
- Used as the program loader: a host or test sequencer feeds requests over a valid/ready handshake.
- Optionally pads the unused tail of program memory with NOPs.

Parameters:
- ADDR_W, 8, program memory address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  system clock
- sync_reset_n  in  1  synchronous reset, active low
- start  in  1  begin a load session at address 0
- finish  in  1  end the session
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_class  in  3  0 LOAD, 1 MOVE, 2 ALU, 3 JUMP, 4 CJUMP; 5-7 illegal
- req_dst  in  3  LOAD/MOVE destination register code
- req_src  in  3  MOVE source register code
- req_data  in  4  LOAD immediate, ALU func in [2:0], JUMP/CJUMP target
- req_x_sel  in  1  ALU x operand select
- req_y_sel  in  1  ALU y operand select
- pm_wr_en  out  1  program memory write strobe
- pm_wr_addr  out  ADDR_W  write address
- pm_wr_data  out  8  encoded instruction
- instr_count  out  ADDR_W+1  words written this session, padding excluded
- illegal  out  1  sticky: an illegal class was accepted this session
- done  out  1  session complete

Behaviour:
- Clock and reset: single clock clk; sync_reset_n is synchronous and active low.
- Encoding:
  - LOAD = {1'b0, dst, data}
  - MOVE = {2'b10, dst, src}
  - ALU = {3'b110, x_sel, y_sel, data[2:0]}
  - JUMP = {4'b1110, data}
  - CJUMP = {4'b1111, data}
  - NOP = 8'h80 (MOVE x0<-x0).
- Reset (sync_reset_n=0 at a clk edge): state IDLE. All outputs are 0, including req_ready, pm_wr_en, pm_wr_addr, pm_wr_data, instr_count, illegal and done. A reset mid-session abandons it; no further writes occur.
- States: IDLE, STREAM, PAD, DONE.
- IDLE: req_ready=0. start -> STREAM with address counter=0, instr_count=0, illegal=0.
- STREAM:
  - req_ready=1 while count<DEPTH.
  - On an accepted legal request at edge N: pm_wr_en=1 with pm_wr_addr/pm_wr_data valid in cycle N+1 (one-cycle registered latency); address and instr_count increment.
  - Back-to-back acceptance gives one write per cycle.
  - An accepted illegal class produces no write and no count change, and sets illegal.
- Full: the edge that accepts the DEPTH-th legal word moves to DONE, and req_ready drops in the following cycle. There is no address wrap.
- finish in STREAM -> PAD if padding is compiled in and count<DEPTH, else DONE.
  - If finish and an accepted request coincide, the request is written, then finish takes effect (same edge).
- PAD (feature only): req_ready=0. Writes NOP to the next address each cycle up to DEPTH-1, then -> DONE.
- DONE: done=1, req_ready=0. start -> STREAM, reinitialising the session; illegal clears.
- pm_wr_en is a one-cycle pulse per write. pm_wr_addr and pm_wr_data hold their last values when pm_wr_en=0.
- start in STREAM/PAD is ignored.

Optional Feature:
- INSTR_ENCODER_NOP_PAD_EN
  - Defined: finish fills the remaining addresses with 8'h80 via the PAD state.
  - Undefined: the PAD state is absent; finish goes straight to DONE, and unwritten memory is left untouched.

Decomposition:
- Package instr_encoder_pkg holds:
  - the instr_class_t enum (LOAD, MOVE, ALU, JUMP, CJUMP)
  - opcode prefix constants
  - register codes (X0=0, X1=1, Y0=2, Y1=3, R/O=4, M=5, I=6, DM=7)
  - NOP_WORD=8'h80
- One combinational sub-module, instr_pack, maps class+fields to an 8-bit word plus an illegal flag. The FSM, counters and write register live in instruction_encoder.

Test Plan:
- start; LOAD dst=0 data=5 -> next cycle pm_wr_en=1, addr 0, data 8'h05; instr_count=1.
- Back-to-back MOVE dst=4 src=6, ALU x=1 y=0 func=3, JUMP 9, CJUMP 2 -> consecutive writes 8'hA6, 8'hD3, 8'hE9, 8'hF2 at addr 0-3, req_ready continuously 1.
- class=6 between two LOADs -> no write for it, illegal=1, addresses contiguous, instr_count=2.
- ADDR_W=2: four legal requests -> addr 0-3 written, req_ready=0 after fourth, done=1; fifth req_valid is never accepted.
- ADDR_W=3, macro defined: two writes then finish -> addr 2-7 written 8'h80 on six consecutive cycles, then done=1, instr_count=2. Macro undefined -> done next cycle, no pad writes.
- sync_reset_n=0 mid-STREAM -> next cycle all outputs 0, state IDLE; a later start restarts at addr 0.
